cam_pattern_gen: RTL and testbench



---
 rtl/cam_gen_pkg.sv | 43 ++++
 rtl/cam_timing.sv | 123 ++++++++++++
 rtl/cam_pattern_gen.sv | 137 +++++++++++++
 tb/tb_cam_pattern_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_gen_pkg.sv
// -----------------------------------------------------------------------------
// cam_gen_pkg
// Shared constants and helpers for the camera pattern generator:
//   - pattern mode encodings
//   - the eight colour-bar values (RGB565)
//   - LFSR seed, tap mask and single-step function
//   - frame geometry helpers (line length and frame height in PCLK/lines)
// -----------------------------------------------------------------------------
package cam_gen_pkg;

    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_LFSR  = 2'd3;

    // White, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [15:0] BAR_COLORS [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1:
    // feedback is the XOR of state bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

    // PCLK cycles per line: active bytes plus horizontal blank.
    function automatic int calc_h_total(input int h_active, input int bpp,
                                        input int h_blank);
        return h_active * bpp + h_blank;
    endfunction

    // Lines per frame: vsync + back porch + active + front porch.
    function automatic int calc_v_total(input int vsync_lines, input int v_back,
                                        input int v_active, input int v_front);
        return vsync_lines + v_back + v_active + v_front;
    endfunction

endpackage

// File: rtl/cam_timing.sv
// -----------------------------------------------------------------------------
// cam_timing
// IDLE/RUN sequencer and line/frame counters for the camera pattern generator.
// All decoded outputs describe the position the counters move to on the
// coming edge, so the parent can register its outputs on that same edge and
// stay aligned with the counters (no sync/data skew).
//
// Ports:
//   clk           pixel clock, rising edge
//   rst_n         asynchronous active-low reset
//   en            run enable, only looked at in IDLE and on a frame's last cycle
//   vsync_d       next position lies in the vsync lines
//   href_d        next position carries an active data byte
//   frame_start_d next position is cycle 0 of a running frame
//   last_cycle    current position is the final cycle of a running frame
//   x_d           next pixel column (hcnt / BPP)
//   y_cell_d      bit 3 of the next active-line index (8-row cell parity)
//   byte_d        next byte index within the pixel (0 = first byte)
// -----------------------------------------------------------------------------
module cam_timing #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int BPP         = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        vsync_d,
    output logic        href_d,
    output logic        frame_start_d,
    output logic        last_cycle,
    output logic [15:0] x_d,
    output logic        y_cell_d,
    output logic        byte_d
);
    import cam_gen_pkg::*;

    localparam int H_TOTAL   = calc_h_total(H_ACTIVE, BPP, H_BLANK);
    localparam int V_TOTAL   = calc_v_total(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT);
    localparam int HCW       = $clog2(H_TOTAL + 1);
    localparam int VCW       = $clog2(V_TOTAL + 1);
    localparam int H_BYTES   = H_ACTIVE * BPP;
    localparam int ACT_FIRST = VSYNC_LINES + V_BACK;
    localparam int ACT_END   = ACT_FIRST + V_ACTIVE;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic [VCW-1:0] vcnt_q, vcnt_d;
    logic           line_end;
    logic           frame_end;
    logic           run_d;
    logic           active_line_d;

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        line_end  = (hcnt_q == HCW'(H_TOTAL - 1));
        frame_end = (state_q == ST_RUN) && line_end && (vcnt_q == VCW'(V_TOTAL - 1));

        case (state_q)
            ST_IDLE: begin
                // Counters already sit at 0, so the first RUN edge is cycle 0.
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (frame_end) begin
                    hcnt_d = '0;
                    vcnt_d = '0;
                    if (!en) begin
                        state_d = ST_IDLE;
                    end
                end else if (line_end) begin
                    hcnt_d = '0;
                    vcnt_d = vcnt_q + VCW'(1);
                end else begin
                    hcnt_d = hcnt_q + HCW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end

    // Decode of the upcoming position.
    always_comb begin
        run_d         = (state_d == ST_RUN);
        active_line_d = (vcnt_d >= VCW'(ACT_FIRST)) && (vcnt_d < VCW'(ACT_END));
        vsync_d       = run_d && (vcnt_d < VCW'(VSYNC_LINES));
        href_d        = run_d && active_line_d && (hcnt_d < HCW'(H_BYTES));
        frame_start_d = run_d && (hcnt_d == '0) && (vcnt_d == '0);
        last_cycle    = frame_end;
        if (BPP == 2) begin
            x_d    = 16'(hcnt_d >> 1);
            byte_d = hcnt_d[0];
        end else begin
            x_d    = 16'(hcnt_d);
            byte_d = 1'b0;
        end
        // Only the 8-row cell parity of y is needed downstream.
        y_cell_d = 1'((16'(vcnt_d) - 16'(ACT_FIRST)) >> 3);
    end

endmodule

// File: rtl/cam_pattern_gen.sv
// -----------------------------------------------------------------------------
// cam_pattern_gen
// OV7670-style camera stimulus source: VSYNC / HREF / byte data with selectable
// test patterns (ramp, colour bars, checkerboard, LFSR noise). Start/stop is
// frame-granular; MODE is latched at each frame start.
//
// Ports:
//   PCLK        pixel clock, rising edge
//   RST_N       asynchronous active-low reset
//   EN          run enable, honoured only at frame boundaries
//   MODE[1:0]   pattern select, latched at frame start
//   CamVsync    high during the vsync lines
//   CamHsync    HREF, high exactly while a data byte is driven
//   CamData     pixel byte stream, 0 outside HREF
//   FrameStart  one-cycle pulse on cycle 0 of each frame
//   FrameCnt    completed-frame count, wraps at 255
// -----------------------------------------------------------------------------
module cam_pattern_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int BPP         = 2
) (
    input  logic       PCLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic [1:0] MODE,
    output logic       CamVsync,
    output logic       CamHsync,
    output logic [7:0] CamData,
    output logic       FrameStart,
    output logic [7:0] FrameCnt
);
    import cam_gen_pkg::*;

    localparam int BAR_PX = H_ACTIVE / 8;

    logic        vsync_d, href_d, frame_start_d, last_cycle, byte_d, y_cell_d;
    logic [15:0] x_d;

    cam_timing #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT),
        .BPP         (BPP)
    ) u_timing (
        .clk           (PCLK),
        .rst_n         (RST_N),
        .en            (EN),
        .vsync_d       (vsync_d),
        .href_d        (href_d),
        .frame_start_d (frame_start_d),
        .last_cycle    (last_cycle),
        .x_d           (x_d),
        .y_cell_d      (y_cell_d),
        .byte_d        (byte_d)
    );

    logic        vsync_q, href_q, frame_start_q;
    logic [7:0]  data_q, data_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        pix_last_q, pix_last_d;
    logic [15:0] pixel;
    logic [2:0]  bar_idx;
    logic [7:0]  byte_sel;

    always_comb begin
        // The count bumps on the edge leaving a frame's last cycle, so every
        // cycle of a frame (including its checker phase) sees one stable value.
        frame_cnt_d = last_cycle ? frame_cnt_q + 8'd1 : frame_cnt_q;
        mode_d      = frame_start_d ? MODE : mode_q;

        // lfsr_q is the value of the pixel currently on the bus; it advances
        // after that pixel's last byte and restarts with every frame.
        lfsr_d = lfsr_q;
        if (frame_start_d) begin
            lfsr_d = LFSR_SEED;
        end else if (pix_last_q) begin
            lfsr_d = lfsr_step(lfsr_q);
        end

        bar_idx = 3'(x_d / 16'(BAR_PX));
        pixel   = 16'h0000;
        case (mode_d)
            MODE_RAMP:  pixel = {x_d[7:0], x_d[7:0]};
            MODE_BARS:  pixel = BAR_COLORS[bar_idx];
            MODE_CHECK: pixel = {16{x_d[3] ^ y_cell_d ^ frame_cnt_d[0]}};
            MODE_LFSR:  pixel = lfsr_d;
            default:    pixel = lfsr_d;
        endcase

        if (BPP == 2) begin
            byte_sel = byte_d ? pixel[7:0] : pixel[15:8];
        end else begin
            byte_sel = pixel[7:0];
        end
        data_d     = href_d ? byte_sel : 8'h00;
        pix_last_d = href_d && ((BPP == 1) || byte_d);
    end

    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            data_q        <= 8'h00;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'h00;
            mode_q        <= 2'd0;
            lfsr_q        <= LFSR_SEED;
            pix_last_q    <= 1'b0;
        end else begin
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            mode_q        <= mode_d;
            lfsr_q        <= lfsr_d;
            pix_last_q    <= pix_last_d;
        end
    end

    assign CamVsync   = vsync_q;
    assign CamHsync   = href_q;
    assign CamData    = data_q;
    assign FrameStart = frame_start_q;
    assign FrameCnt   = frame_cnt_q;

endmodule

// File: tb/tb_cam_pattern_gen.sv
module tb_cam_pattern_gen;
    localparam int HA = 8, VA = 3, HB = 2, VS = 1, VB = 1, VF = 1, BP = 2;
    localparam int H_TOT  = HA * BP + HB;        // 18
    localparam int V_TOT  = VS + VB + VA + VF;   // 6
    localparam int F_CYC  = H_TOT * V_TOT;       // 108
    localparam int ACT0   = VS + VB;
    localparam int NPIX   = HA * VA;
    localparam int NBYTES = NPIX * BP;

    logic       PCLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       EN = 1'b0;
    logic [1:0] MODE = 2'd0;
    logic       CamVsync, CamHsync, FrameStart;
    logic [7:0] CamData, FrameCnt;

    always #5 PCLK = ~PCLK;

    cam_pattern_gen #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(VS),
        .V_BACK(VB), .V_FRONT(VF), .BPP(BP)
    ) dut (
        .PCLK(PCLK), .RST_N(RST_N), .EN(EN), .MODE(MODE),
        .CamVsync(CamVsync), .CamHsync(CamHsync), .CamData(CamData),
        .FrameStart(FrameStart), .FrameCnt(FrameCnt)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state: running?, cycle within frame, latched mode, frames done.
    bit         m_run = 1'b0;
    int         m_c = 0;
    logic [1:0] m_mode = 2'd0;
    logic [7:0] m_fc = 8'd0;

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [15:0] lfsr_tab [NPIX];

    logic [7:0]   cap [NBYTES];
    logic [7:0]   gold0 [NBYTES];
    logic [7:0]   cap_a [NBYTES];
    int           cap_idx = 0;
    logic [127:0] line_cap = '0;
    int           fs_seen, vs_seen, hs_seen, bursts;
    logic         prev_hs = 1'b0;

    function automatic logic [15:0] model_pixel(input int x, input int y);
        logic [15:0] xv;
        xv = 16'(x);
        case (m_mode)
            2'd0:    return {xv[7:0], xv[7:0]};
            2'd1:    return bars[x / (HA / 8)];
            2'd2:    return (((x / 8) + (y / 8) + int'(m_fc)) % 2 == 1) ? 16'hFFFF : 16'h0000;
            default: return lfsr_tab[y * HA + x];
        endcase
    endfunction

    // {FrameStart, CamVsync, CamHsync, CamData, FrameCnt}
    function automatic logic [18:0] model_out();
        int line, col;
        logic vs, hs, fs;
        logic [15:0] p;
        logic [7:0] d;
        if (!m_run) return {11'd0, m_fc};
        line = m_c / H_TOT;
        col  = m_c % H_TOT;
        fs   = (m_c == 0);
        vs   = (line < VS);
        hs   = (line >= ACT0) && (line < ACT0 + VA) && (col < HA * BP);
        d    = 8'h00;
        if (hs) begin
            p = model_pixel(col / BP, line - ACT0);
            d = (col % BP == 0) ? p[15:8] : p[7:0];
        end
        return {fs, vs, hs, d, m_fc};
    endfunction

    task automatic model_advance();
        if (!m_run) begin
            if (EN) begin
                m_run = 1'b1; m_c = 0; m_mode = MODE;
            end
        end else if (m_c == F_CYC - 1) begin
            m_fc = m_fc + 8'd1;
            if (EN) begin
                m_c = 0; m_mode = MODE;
            end else begin
                m_run = 1'b0; m_c = 0;
            end
        end else begin
            m_c++;
        end
    endtask

    task automatic check(input string tag);
        logic [18:0] obs, exp;
        obs = {FrameStart, CamVsync, CamHsync, CamData, FrameCnt};
        exp = model_out();
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, m_c, obs, exp);
        end
    endtask

    task automatic cmp(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        fs_seen = 0; vs_seen = 0; hs_seen = 0; bursts = 0;
    endtask

    task automatic step(input string tag);
        @(posedge PCLK);
        if (RST_N) model_advance();
        #1;
        check(tag);
        if (FrameStart) fs_seen++;
        if (CamVsync) vs_seen++;
        if (m_run && m_c == 0) cap_idx = 0;
        if (CamHsync) begin
            hs_seen++;
            if (!prev_hs) bursts++;
            line_cap = {line_cap[119:0], CamData};
            if (cap_idx < NBYTES) begin
                cap[cap_idx] = CamData;
                cap_idx++;
            end
        end
        prev_hs = CamHsync;
    endtask

    task automatic step_until(input int target, input string tag);
        int n;
        n = 0;
        while (!(m_run && m_c == target) && n < 400) begin
            step(tag);
            n++;
        end
        if (!(m_run && m_c == target)) begin
            tests++;
            fails++;
            $error("FAIL %s_timeout observed=cyc%0d expected=cyc%0d", tag, m_c, target);
        end
    endtask

    task automatic run_frame(input string tag);
        repeat (F_CYC) step(tag);
    endtask

    int          ndiff;
    logic [7:0]  f6_byte0, fc_before;

    initial begin
        begin
            logic [15:0] s;
            logic fb;
            s = 16'hACE1;
            for (int i = 0; i < NPIX; i++) begin
                lfsr_tab[i] = s;
                fb = s[0] ^ s[2] ^ s[3] ^ s[5];
                s  = {fb, s[15:1]};
            end
        end

        // Reset state.
        repeat (3) @(posedge PCLK);
        #1;
        check("reset");

        // Free-running ramp frame.
        RST_N = 1'b1; EN = 1'b1; MODE = 2'd0;
        clear_stats();
        run_frame("frame0_ramp");
        cmp("fs_per_frame", 128'(fs_seen), 128'd1);
        cmp("vsync_cycles", 128'(vs_seen), 128'd18);
        cmp("href_bursts", 128'(bursts), 128'd3);
        cmp("href_cycles", 128'(hs_seen), 128'd48);
        cmp("ramp_line", line_cap, 128'h0000_0101_0202_0303_0404_0505_0606_0707);
        gold0 = cap;
        step("frame1_start");
        cmp("fs_period_108", 128'(FrameStart), 128'd1);
        cmp("framecnt_after_1", 128'(FrameCnt), 128'd1);

        // Colour bars (frame 1 keeps its latched ramp mode).
        MODE = 2'd1;
        step_until(F_CYC - 1, "frame1");
        run_frame("frame2_bars");
        cmp("bars_line", line_cap, 128'hFFFF_FFE0_07FF_07E0_F81F_F800_001F_0000);

        // Mode change mid-frame only takes effect on the next frame.
        MODE = 2'd0;
        step("frame3_start");
        step_until(40, "frame3");
        MODE = 2'd3;
        step_until(F_CYC - 1, "frame3");
        cmp("mode_held_ramp", line_cap, 128'h0000_0101_0202_0303_0404_0505_0606_0707);
        run_frame("frame4_lfsr");
        cap_a = cap;
        cmp("lfsr_first_pixel", {112'd0, cap_a[0], cap_a[1]}, 128'hACE1);
        run_frame("frame5_lfsr");
        ndiff = 0;
        for (int i = 0; i < NBYTES; i++) if (cap[i] !== cap_a[i]) ndiff++;
        cmp("lfsr_frames_identical", 128'(ndiff), 128'd0);

        // Checkerboard inverts frame to frame.
        MODE = 2'd2;
        run_frame("frame6_check");
        f6_byte0 = cap[0];
        run_frame("frame7_check");
        cmp("checker_inverts", {120'd0, cap[0]}, {120'd0, ~f6_byte0});

        // EN dropped mid-frame: frame completes, then idle.
        MODE = 2'd0;
        step_until(40, "frame8");
        EN = 1'b0;
        fc_before = FrameCnt;
        step_until(F_CYC - 1, "frame8_drain");
        step("enter_idle");
        cmp("framecnt_after_stop", 128'(FrameCnt), 128'(fc_before + 8'd1));
        clear_stats();
        repeat (20) step("idle");
        cmp("idle_no_framestart", 128'(fs_seen), 128'd0);
        cmp("idle_no_href", 128'(hs_seen + vs_seen), 128'd0);
        EN = 1'b1;
        step("restart");
        cmp("restart_fs_next_edge", 128'(FrameStart), 128'd1);

        // Asynchronous reset in the middle of an HREF burst.
        step_until(40, "pre_reset");
        cmp("pre_reset_href", 128'(CamHsync), 128'd1);
        #3;
        RST_N = 1'b0;
        #1;
        cmp("async_reset_outputs",
            128'({FrameStart, CamVsync, CamHsync, CamData, FrameCnt}), 128'd0);
        m_run = 1'b0; m_c = 0; m_mode = 2'd0; m_fc = 8'd0; prev_hs = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        RST_N = 1'b1;
        run_frame("post_reset");
        ndiff = 0;
        for (int i = 0; i < NBYTES; i++) if (cap[i] !== gold0[i]) ndiff++;
        cmp("post_reset_matches_frame0", 128'(ndiff), 128'd0);

        // Randomised mode / enable activity against the model.
        repeat (1500) begin
            if ($urandom_range(0, 19) == 0) MODE = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) EN = ~EN;
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
